// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty/mode
// double-buffered so every change lands on a period boundary.
module pwm_ch #(
    parameter int PERIOD = 5000,
    parameter int CW     = 13,
    parameter int DW     = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          ld_act_i,
    input  logic          ld_pend_i,
    input  logic          sel_in_i,
    input  logic [DW-1:0] duty_i,
    input  logic          mode_i,
    input  logic [CW-1:0] cnt_i,
    output logic          pwm_o
);
    logic [DW-1:0]    pduty_q;
    logic             pmode_q;
    logic [CW-1:0]    alo_q, alo_d;
    logic [CW:0]      ahi_q, ahi_d;
    logic [CW:0]      thr, lo_c;
    logic [CW+DW-1:0] prod;
    logic [DW-1:0]    src_duty;
    logic             src_mode;
    logic             pwm_q;

    // Only the window bounds are kept in the active set; they are all the
    // output compare needs, so duty/mode are folded in at load time.
    always_comb begin
        src_duty = sel_in_i ? duty_i : pduty_q;
        src_mode = sel_in_i ? mode_i : pmode_q;
        prod     = (CW+DW)'(PERIOD) * (CW+DW)'(src_duty);
        thr      = (CW+1)'(prod >> DW);
        lo_c     = ((CW+1)'(PERIOD) - thr) >> 1;
        alo_d    = src_mode ? CW'(lo_c) : '0;
        ahi_d    = {1'b0, alo_d} + thr;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pduty_q <= '0;
            pmode_q <= 1'b0;
            alo_q   <= '0;
            ahi_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            if (ld_pend_i) begin
                pduty_q <= duty_i;
                pmode_q <= mode_i;
            end
            if (ld_act_i) begin
                alo_q <= alo_d;
                ahi_q <= ahi_d;
            end
            pwm_q <= i_en && (alo_q <= cnt_i) && ({1'b0, cnt_i} < ahi_q);
        end
    end

    assign pwm_o = pwm_q;
endmodule

module pwm_multi_gen #(
    parameter int CLK_HZ = 100000000,
    parameter int PWM_HZ = 20000,
    parameter int NCH    = 4,
    parameter int DW     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [NCH*DW-1:0] i_duty,
    input  logic [NCH-1:0]    i_mode,
    input  logic              i_load,
    output logic [NCH-1:0]    o_pwm,
    output logic              o_period,
    output logic              o_pend
);
    localparam int PERIOD = CLK_HZ / PWM_HZ;
    localparam int CW     = $clog2(PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          period_q;
    logic          wrap, ld_act, ld_pend;

    assign wrap = i_en && (cnt_q == CW'(PERIOD - 1));

    // A load on the wrap cycle (or while disabled) bypasses the pending set,
    // so fresh input data always beats anything older still waiting.
    always_comb begin
        cnt_d   = '0;
        if (i_en && !wrap) cnt_d = cnt_q + 1'b1;
        ld_act  = (!i_en && i_load) || (wrap && (i_load || pend_q));
        ld_pend = i_en && !wrap && i_load;
        pend_d  = pend_q;
        if (ld_pend)     pend_d = 1'b1;
        else if (ld_act) pend_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            period_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            period_q <= wrap;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        pwm_ch #(.PERIOD(PERIOD), .CW(CW), .DW(DW)) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (i_en),
            .ld_act_i  (ld_act),
            .ld_pend_i (ld_pend),
            .sel_in_i  (i_load),
            .duty_i    (i_duty[c*DW +: DW]),
            .mode_i    (i_mode[c]),
            .cnt_i     (cnt_q),
            .pwm_o     (o_pwm[c])
        );
    end

    assign o_period = period_q;
    assign o_pend   = pend_q;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the period/window rules.
module tb_pwm_multi_gen;
    localparam int NCH    = 4;
    localparam int DW     = 8;
    localparam int CLK_HZ = 4_000_000;
    localparam int PWM_HZ = 20_000;
    localparam int P      = CLK_HZ / PWM_HZ;   // 200

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              load = 1'b0;
    logic [NCH*DW-1:0] duty = '0;
    logic [NCH-1:0]    mode = '0;
    logic [NCH-1:0]    pwm;
    logic              period, pend;

    always #5 clk = ~clk;

    pwm_multi_gen #(.CLK_HZ(CLK_HZ), .PWM_HZ(PWM_HZ), .NCH(NCH), .DW(DW)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_duty(duty), .i_mode(mode),
        .i_load(load), .o_pwm(pwm), .o_period(period), .o_pend(pend)
    );

    int n_chk = 0, n_fail = 0;

    // model state
    int             m_cnt;
    int             m_ad[NCH], m_am[NCH], m_pd[NCH], m_pm[NCH];
    bit             m_pend, m_per;
    logic [NCH-1:0] m_pwm;
    int             m_hi[NCH], m_first[NCH];

    function automatic int thr_of(int d);
        return (P * d) / (1 << DW);
    endfunction

    function automatic bit in_win(int d, int m, int k);
        int t  = thr_of(d);
        int lo = m ? (P - t) / 2 : 0;
        return (k >= lo) && (k < lo + t);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pend = 0; m_per = 0; m_pwm = '0;
        for (int c = 0; c < NCH; c++) begin
            m_ad[c] = 0; m_am[c] = 0; m_pd[c] = 0; m_pm[c] = 0;
        end
    endtask

    task automatic tick();
        logic [NCH-1:0] np;
        bit w;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            w = en && (m_cnt == P - 1);
            for (int c = 0; c < NCH; c++) np[c] = en && in_win(m_ad[c], m_am[c], m_cnt);
            if (!en) begin
                if (load) begin
                    for (int c = 0; c < NCH; c++) begin
                        m_ad[c] = int'(duty[c*DW +: DW]); m_am[c] = int'(mode[c]);
                    end
                    m_pend = 0;
                end
            end else if (w) begin
                for (int c = 0; c < NCH; c++) begin
                    if (load) begin
                        m_ad[c] = int'(duty[c*DW +: DW]); m_am[c] = int'(mode[c]);
                    end else if (m_pend) begin
                        m_ad[c] = m_pd[c]; m_am[c] = m_pm[c];
                    end
                end
                m_pend = 0;
            end else if (load) begin
                for (int c = 0; c < NCH; c++) begin
                    m_pd[c] = int'(duty[c*DW +: DW]); m_pm[c] = int'(mode[c]);
                end
                m_pend = 1;
            end
            m_cnt = (!en || w) ? 0 : m_cnt + 1;
            m_pwm = np;
            m_per = w;
        end
        #1;
        chk("pwm", pwm, m_pwm);
        chk("period", period, m_per);
        chk("pend", pend, m_pend);
    endtask

    task automatic tick_to(int k);
        int n = 0;
        while (m_cnt != k && n < 2 * P) begin tick(); n++; end
        chk("reach_cnt", m_cnt, k);
    endtask

    task automatic pulse_load(logic [NCH*DW-1:0] d, logic [NCH-1:0] m);
        duty = d; mode = m; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // One full period of outputs starting at the o_period cycle.
    task automatic measure();
        int k = 0;
        while (!period && k < 2 * P) begin tick(); k++; end
        chk("period_found", period, 1);
        for (int c = 0; c < NCH; c++) begin m_hi[c] = 0; m_first[c] = -1; end
        for (int i = 0; i < P; i++) begin
            if (i > 0) tick();
            for (int c = 0; c < NCH; c++)
                if (pwm[c]) begin
                    m_hi[c]++;
                    if (m_first[c] < 0) m_first[c] = i;
                end
        end
    endtask

    initial begin
        int k;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // edge 50%, center 50%, duty 0, duty 255; loaded while disabled
        pulse_load({8'd255, 8'd0, 8'd128, 8'd128}, 4'b0010);
        chk("pend_disabled_load", pend, 0);
        en = 1'b1;
        measure();
        chk("edge50_hi", m_hi[0], 100);
        chk("edge50_first", m_first[0], 1);
        chk("center50_hi", m_hi[1], 100);
        chk("center50_first", m_first[1], 51);
        chk("duty0_hi", m_hi[2], 0);
        chk("duty255_hi", m_hi[3], 199);

        // mid-period update: 64 -> 192
        tick_to(10);
        pulse_load({8'd255, 8'd0, 8'd128, 8'd64}, 4'b0010);
        measure();
        chk("duty64_hi", m_hi[0], 50);
        tick_to(50);
        pulse_load({8'd255, 8'd0, 8'd128, 8'd192}, 4'b0010);
        chk("pend_mid", pend, 1);
        measure();
        chk("duty192_hi", m_hi[0], 150);

        // stale pending vs load on the wrap cycle
        tick_to(100);
        pulse_load({8'd255, 8'd0, 8'd128, 8'd200}, 4'b0010);
        tick_to(P - 1);
        pulse_load({8'd255, 8'd0, 8'd128, 8'd32}, 4'b0010);
        chk("pend_wrap_load", pend, 0);
        measure();
        chk("wrap_load_hi", m_hi[0], 25);

        // two loads in one period: last wins
        tick_to(20);
        pulse_load({8'd255, 8'd0, 8'd128, 8'd100}, 4'b0010);
        tick_to(60);
        pulse_load({8'd255, 8'd0, 8'd128, 8'd160}, 4'b0010);
        measure();
        chk("last_load_hi", m_hi[0], 125);

        // disable mid-period, then re-enable gives a clean full period
        tick_to(80);
        en = 1'b0;
        tick();
        chk("dis_pwm", pwm, 0);
        en = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!period && k < 2 * P);
        chk("reen_period_gap", k, P);

        // asynchronous reset mid-period with a load pending
        tick_to(60);
        pulse_load({8'd10, 8'd20, 8'd30, 8'd40}, 4'b1111);
        tick_to(70);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pwm", pwm, 0);
        chk("rst_period", period, 0);
        chk("rst_pend", pend, 0);
        tick();
        rst_n = 1'b1;
        measure();
        for (int c = 0; c < NCH; c++) chk("post_rst_hi", m_hi[c], 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            duty = {$urandom, $urandom};
            mode = NCH'($urandom);
            load = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 399) == 0) en = ~en;
            tick();
        end
        load = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
